ram_bus_master: RTL
===================

Name: ram_bus_master

Overview:
Bus-master front end that sits directly upstream of the team's synchronous 8-bit RAM and is the only agent driving its chip-select, write-enable, read-enable, address and write-data lines. It accepts single-beat read/write requests over a valid/ready handshake and sequences the RAM's multi-cycle read timing. It returns one response per request, with read data or an error flag, over a second valid/ready handshake.

Parameters:
ADDR_W, 16, address width of request and RAM address bus
DATA_W, 8, data width
MEM_DEPTH, 10000, number of implemented RAM locations; addresses >= MEM_DEPTH are rejected
READ_HOLD, 2, clocks chipsel+readEn are held per read (min 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready at rising edge
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  address out of range, no RAM access made
chipsel  out  1  RAM chip select
writeEn  out  1  RAM write enable
readEn  out  1  RAM read enable
addrOut  out  ADDR_W  RAM address
busIn  out  DATA_W  RAM write data (named from RAM's view)
busOut  in  DATA_W  RAM read data, registered inside RAM

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0 during reset, 1 from first clock after release; rsp_valid=0, rsp_rdata=0, rsp_err=0, chipsel=writeEn=readEn=0, addrOut=0, busIn=0, hold counter=0. Reset mid-transaction drops it; RAM enables fall immediately, no response issued.
- All RAM-side outputs and rsp_* are registers; no combinational path from req_* or rsp_ready to any output except req_ready (= state==IDLE).
- States: IDLE, WRITE, RD_HOLD, RD_SAMPLE, RESP.
- IDLE: req_ready=1. On req_valid: latch addr/wdata/write into addrOut/busIn.
  - addr >= MEM_DEPTH -> RESP, rsp_err=1, rsp_rdata=0; chipsel never asserted.
  - write -> WRITE, chipsel=writeEn=1.
  - read -> RD_HOLD, chipsel=readEn=1, counter=READ_HOLD-1.
- WRITE: exactly one cycle with enables high (RAM writes on the edge leaving it) -> RESP, enables 0, rsp_err=0, rsp_rdata=0.
- RD_HOLD: enables held, addrOut stable; counter decrements each edge; at counter==0 -> RD_SAMPLE, enables 0.
- RD_SAMPLE: one cycle, no enables; busOut captured into rsp_rdata on the edge leaving it -> RESP.
- RESP: rsp_valid=1, rsp_* stable until rsp_valid&rsp_ready; then -> IDLE, rsp_valid=0. Backpressure holds indefinitely.
- Latency (accept edge = E0): write rsp_valid visible after E1; read (READ_HOLD=2) rsp_valid visible after E3. Next request accepted no earlier than the edge after the rsp handshake edge (one outstanding request, no overlap).
- Address MEM_DEPTH-1 is valid; MEM_DEPTH and 16'hFFFF return error.
- req_* ignored outside IDLE; req_valid must be held by upstream until accepted.

Decomposition:
- Package ram_bus_pkg: state enum (IDLE, WRITE, RD_HOLD, RD_SAMPLE, RESP), ADDR_W/DATA_W/MEM_DEPTH defaults, and a counter width derived from READ_HOLD.
- No sub-module; the hold counter is inline. The bench instantiates the existing synchronous RAM as the downstream load.

Test Plan:
- Reset: rst_n low mid-RD_HOLD -> chipsel/readEn drop immediately with no clock; after release req_ready=1, rsp_valid=0.
- Write then read: write addr 16'h0010 data 8'hA5, then read 16'h0010 -> write response err=0 one cycle after accept; read response rdata=8'hA5, rsp_valid 3 edges after accept.
- Range: read 16'd9999 -> normal access; read 16'd10000 and write 16'hFFFF -> rsp_err=1, rdata=0, chipsel never high.
- Backpressure: rsp_ready low 5 cycles on a read of 8'h3C -> rsp_valid and rdata=8'h3C stable; req_ready=0 throughout; new request accepted the cycle after the handshake.
- Back-to-back: 4 writes (addr 0..3, data 8'h11..8'h44) followed by 4 reads with rsp_ready tied high -> reads return 11,22,33,44 in order; readEn high exactly READ_HOLD cycles per read.
- Enable discipline: random traffic -> writeEn and readEn never high together; chipsel high iff one of them is high; addrOut stable for the whole assertion.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the RAM bus master.
// Contents: default bus widths, the implemented RAM depth, the read-hold length,
// the controller state encoding and a helper that sizes the read-hold counter.
package ram_bus_pkg;

  localparam int unsigned ADDR_W_DEF    = 16;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MEM_DEPTH_DEF = 10000;
  localparam int unsigned READ_HOLD_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_HOLD,
    RD_SAMPLE,
    RESP
  } state_e;

  // The counter is loaded with hold-1 and counts down to zero, so it only needs
  // enough bits for hold-1. At least one bit is kept so the port never collapses.
  function automatic int unsigned cnt_width(input int unsigned hold);
    return (hold > 2) ? $clog2(hold) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(READ_HOLD_DEF);

endpackage

// File: rtl/ram_bus_master.sv
// Bus-master front end for the synchronous 8-bit RAM.
// Accepts single-beat read/write requests (req_*), sequences the RAM strobes and
// returns exactly one response per request (rsp_*). One request outstanding at a time.
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   req_valid/req_ready         request handshake; req_write, req_addr, req_wdata payload
//   rsp_valid/rsp_ready         response handshake; rsp_rdata, rsp_err payload
//   chipsel, writeEn, readEn    RAM strobes (registered)
//   addrOut, busIn              RAM address and write data (registered)
//   busOut                      RAM read data, registered inside the RAM
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned READ_HOLD = READ_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              chipsel,
  output logic              writeEn,
  output logic              readEn,
  output logic [ADDR_W-1:0] addrOut,
  output logic [DATA_W-1:0] busIn,
  input  logic [DATA_W-1:0] busOut
);

  localparam int unsigned CNT_W = cnt_width(READ_HOLD);
  // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_live;  // low until the first edge after reset release
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_chipsel;
  logic                r_write_en;
  logic                r_read_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic w_accept;
  logic w_out_of_range;

  assign req_ready      = r_live && (r_state == IDLE);
  assign w_accept       = req_ready && req_valid;
  assign w_out_of_range = ({1'b0, req_addr} >= DEPTH_L);

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign chipsel   = r_chipsel;
  assign writeEn   = r_write_en;
  assign readEn    = r_read_en;
  assign addrOut   = r_addr;
  assign busIn     = r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_live      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_chipsel   <= 1'b0;
      r_write_en  <= 1'b0;
      r_read_en   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_out_of_range) begin
              // Rejected without touching the RAM.
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (req_write) begin
              r_state    <= WRITE;
              r_chipsel  <= 1'b1;
              r_write_en <= 1'b1;
            end else begin
              r_state   <= RD_HOLD;
              r_chipsel <= 1'b1;
              r_read_en <= 1'b1;
              r_cnt     <= CNT_W'(READ_HOLD - 1);
            end
          end
        end
        WRITE: begin
          // RAM commits the write on this edge.
          r_state     <= RESP;
          r_chipsel   <= 1'b0;
          r_write_en  <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        RD_HOLD: begin
          if (r_cnt == '0) begin
            r_state   <= RD_SAMPLE;
            r_chipsel <= 1'b0;
            r_read_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RD_SAMPLE: begin
          // busOut is the RAM's registered output from the last strobed edge.
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= busOut;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
